uart_tx_serializer: RTL

Serializes one parallel byte per request into an asynchronous UART frame on the TX clock domain. It sits directly downstream of the system-controller TX path, after the data synchronizer: it consumes P_DATA/Data_Valid and returns Busy, which throttles the controller. Every bit lasts exactly one CLK cycle (CLK is the baud-rate TX clock). It has configurable parity (enable/type) and a single stop bit by default.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_parity_calc.sv | 18 +
 rtl/uart_tx_serializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes and the
// default payload width. Used by the TX serializer and the RX parity checker.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity generator: even parity is the XOR of the data bits, odd parity is
// its inverse. Purely combinational so the RX checker can share it.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Reduce the data word and invert for odd parity
  always_comb begin
    par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one bit per CLK cycle, start bit, LSB-first
// payload, optional parity bit, stop bit. TX_OUT and Busy are registered.
// Build option: define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q, stop2_d;
`endif

  // Parity always reflects the frame's latched byte and type
  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  // State and output registers; reset forces the line idle immediately
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  // Next state; tx_d is the bit the line carries while in state_d
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = data_q[cnt_d];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: begin
        tx_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        if (!stop2_q) begin
          stop2_d = 1'b1;
        end else begin
          stop2_d = 1'b0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
